// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit: funct3 branch encodings and the result payload.
package bru_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    // next_pc is held at the widest supported width and truncated to WIDTH at the output.
    localparam int unsigned BRU_MAX_WIDTH = 64;

    typedef struct packed {
        logic                     taken;
        logic                     mispredict;
        logic                     illegal;
        logic [BRU_MAX_WIDTH-1:0] next_pc;
    } bru_result_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Request/result bus of the branch resolve unit; master is the execute side, slave is the unit.
interface branch_resolve_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imm;
    logic             pred_taken;
    logic [WIDTH-1:0] pred_target;

    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [WIDTH-1:0] out_next_pc;
    logic             out_mispredict;
    logic             out_illegal;

    modport master (
        output in_valid, op1, op2, funct3, pc, imm, pred_taken, pred_target, out_ready,
        input  in_ready, out_valid, out_taken, out_next_pc, out_mispredict, out_illegal
    );

    modport slave (
        input  in_valid, op1, op2, funct3, pc, imm, pred_taken, pred_target, out_ready,
        output in_ready, out_valid, out_taken, out_next_pc, out_mispredict, out_illegal
    );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: funct3/op1/op2 -> taken, illegal (010/011 are not branches).
module branch_cond_eval
    import bru_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    output logic             taken_c_o,
    output logic             illegal_c_o
);

    always_comb begin
        taken_c_o   = 1'b0;
        illegal_c_o = 1'b0;
        case (funct3_i)
            BEQ:     taken_c_o = (op1_i == op2_i);
            BNE:     taken_c_o = (op1_i != op2_i);
            BLT:     taken_c_o = ($signed(op1_i) <  $signed(op2_i));
            BGE:     taken_c_o = ($signed(op1_i) >= $signed(op2_i));
            BLTU:    taken_c_o = (op1_i <  op2_i);
            BGEU:    taken_c_o = (op1_i >= op2_i);
            default: illegal_c_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered, valid/ready branch resolver with one-cycle latency.
// Optional performance counters are built when BRU_PERF_COUNTERS_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    branch_resolve_unit_if.slave  bus
`ifdef BRU_PERF_COUNTERS_EN
    ,
    input  logic                  cnt_clear,
    output logic [CNT_WIDTH-1:0]  cnt_branches,
    output logic [CNT_WIDTH-1:0]  cnt_taken,
    output logic [CNT_WIDTH-1:0]  cnt_mispred
`endif
);

    if (WIDTH < 8 || WIDTH > BRU_MAX_WIDTH || CNT_WIDTH < 1) begin : g_bad_cfg
        $error("branch_resolve_unit: unsupported WIDTH/CNT_WIDTH");
    end

    logic             accept_c;
    logic             taken_c;
    logic             illegal_c;
    logic             mispredict_c;
    logic [WIDTH-1:0] target_c;
    logic [WIDTH-1:0] fallthrough_c;
    logic             valid_d, valid_q;
    bru_result_t      res_d, res_q;

    // Flush blocks acceptance; otherwise accept into an empty slot or one being drained.
    assign bus.in_ready = !flush && (!valid_q || bus.out_ready);
    assign accept_c     = bus.in_valid && bus.in_ready;

    branch_cond_eval #(
        .WIDTH (WIDTH)
    ) u_cond (
        .funct3_i    (bus.funct3),
        .op1_i       (bus.op1),
        .op2_i       (bus.op2),
        .taken_c_o   (taken_c),
        .illegal_c_o (illegal_c)
    );

    always_comb begin
        valid_d       = valid_q;
        res_d         = res_q;
        target_c      = bus.pc + bus.imm;
        fallthrough_c = bus.pc + WIDTH'(4);
        mispredict_c  = illegal_c || (taken_c != bus.pred_taken) ||
                        (taken_c && (bus.pred_target != target_c));
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_c) begin
            valid_d          = 1'b1;
            res_d.taken      = taken_c;
            res_d.illegal    = illegal_c;
            res_d.mispredict = mispredict_c;
            res_d.next_pc    = BRU_MAX_WIDTH'(taken_c ? target_c : fallthrough_c);
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_taken      = res_q.taken;
    assign bus.out_mispredict = res_q.mispredict;
    assign bus.out_illegal    = res_q.illegal;
    assign bus.out_next_pc    = WIDTH'(res_q.next_pc);

`ifdef BRU_PERF_COUNTERS_EN
    logic [CNT_WIDTH-1:0] cnt_br_q, cnt_tk_q, cnt_mp_q;

    // Saturating event counters sampled at accept; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_br_q <= '0;
            cnt_tk_q <= '0;
            cnt_mp_q <= '0;
        end else if (cnt_clear) begin
            cnt_br_q <= '0;
            cnt_tk_q <= '0;
            cnt_mp_q <= '0;
        end else if (accept_c) begin
            if (cnt_br_q != '1)
                cnt_br_q <= cnt_br_q + CNT_WIDTH'(1);
            if (taken_c && (cnt_tk_q != '1))
                cnt_tk_q <= cnt_tk_q + CNT_WIDTH'(1);
            if (mispredict_c && (cnt_mp_q != '1))
                cnt_mp_q <= cnt_mp_q + CNT_WIDTH'(1);
        end
    end

    assign cnt_branches = cnt_br_q;
    assign cnt_taken    = cnt_tk_q;
    assign cnt_mispred  = cnt_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases plus random traffic vs a queue model.
module tb_branch_resolve_unit;

    localparam int unsigned W = 32;
`ifdef BRU_PERF_COUNTERS_EN
    localparam int unsigned CW = 4;
`else
    localparam int unsigned CW = 32;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.WIDTH(W)) bus();

`ifdef BRU_PERF_COUNTERS_EN
    logic          cnt_clear = 1'b0;
    logic [CW-1:0] cnt_b, cnt_t, cnt_m;
    int            m_b, m_t, m_m;
`endif

    branch_resolve_unit #(
        .WIDTH     (W),
        .CNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus)
`ifdef BRU_PERF_COUNTERS_EN
        ,
        .cnt_clear    (cnt_clear),
        .cnt_branches (cnt_b),
        .cnt_taken    (cnt_t),
        .cnt_mispred  (cnt_m)
`endif
    );

    typedef struct {
        logic         taken;
        logic         mis;
        logic         ill;
        logic [W-1:0] npc;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: branch rules evaluated with wide arithmetic and an explicit modulus.
    function automatic exp_t ref_model(input logic [W-1:0] op1, input logic [W-1:0] op2,
                                       input logic [2:0] f3, input logic [W-1:0] pc,
                                       input logic [W-1:0] imm, input logic pt,
                                       input logic [W-1:0] ptgt);
        exp_t            e;
        longint unsigned mask, tgt, fall;
        longint          s1, s2;
        mask = (64'd1 << W) - 64'd1;
        tgt  = (64'(pc) + 64'(imm)) & mask;
        fall = (64'(pc) + 64'd4) & mask;
        s1   = longint'($signed(op1));
        s2   = longint'($signed(op2));
        e.ill   = 1'b0;
        e.taken = 1'b0;
        case (f3)
            3'd0: e.taken = (op1 == op2);
            3'd1: e.taken = (op1 != op2);
            3'd4: e.taken = (s1 < s2);
            3'd5: e.taken = !(s1 < s2);
            3'd6: e.taken = (64'(op1) < 64'(op2));
            3'd7: e.taken = !(64'(op1) < 64'(op2));
            default: e.ill = 1'b1;
        endcase
        e.npc = W'(e.taken ? tgt : fall);
        e.mis = e.ill || (e.taken != pt) || (e.taken && (64'(ptgt) != tgt));
        return e;
    endfunction

    // Monitor on the falling edge: check outputs, then advance the model across the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        logic exp_rdy;
        if (!rst_n) begin
            check_val("rst_out_valid", W'(bus.out_valid), '0);
            check_val("rst_out_taken", W'(bus.out_taken), '0);
            check_val("rst_out_next_pc", bus.out_next_pc, '0);
            check_val("rst_out_mispredict", W'(bus.out_mispredict), '0);
            check_val("rst_out_illegal", W'(bus.out_illegal), '0);
            q.delete();
`ifdef BRU_PERF_COUNTERS_EN
            check_val("rst_cnt_branches", W'(cnt_b), '0);
            check_val("rst_cnt_taken", W'(cnt_t), '0);
            check_val("rst_cnt_mispred", W'(cnt_m), '0);
            m_b = 0; m_t = 0; m_m = 0;
`endif
        end else begin
            exp_rdy = !flush && (q.size() == 0 || bus.out_ready);
            check_val("in_ready", W'(bus.in_ready), W'(exp_rdy));
            check_val("out_valid", W'(bus.out_valid), W'(q.size() != 0));
            if (q.size() != 0) begin
                check_val("out_taken", W'(bus.out_taken), W'(q[0].taken));
                check_val("out_next_pc", bus.out_next_pc, q[0].npc);
                check_val("out_mispredict", W'(bus.out_mispredict), W'(q[0].mis));
                check_val("out_illegal", W'(bus.out_illegal), W'(q[0].ill));
            end
`ifdef BRU_PERF_COUNTERS_EN
            check_val("cnt_branches", W'(cnt_b), W'(m_b));
            check_val("cnt_taken", W'(cnt_t), W'(m_t));
            check_val("cnt_mispred", W'(cnt_m), W'(m_m));
`endif
            e = ref_model(bus.op1, bus.op2, bus.funct3, bus.pc, bus.imm,
                          bus.pred_taken, bus.pred_target);
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
                if (bus.in_valid && exp_rdy) q.push_back(e);
            end
`ifdef BRU_PERF_COUNTERS_EN
            if (cnt_clear) begin
                m_b = 0; m_t = 0; m_m = 0;
            end else if (bus.in_valid && exp_rdy) begin
                if (m_b < 15) m_b++;
                if (e.taken && m_t < 15) m_t++;
                if (e.mis && m_m < 15) m_m++;
            end
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic v, input logic [W-1:0] op1, input logic [W-1:0] op2,
                           input logic [2:0] f3, input logic [W-1:0] pc, input logic [W-1:0] imm,
                           input logic pt, input logic [W-1:0] ptgt);
        bus.in_valid    = v;
        bus.op1         = op1;
        bus.op2         = op2;
        bus.funct3      = f3;
        bus.pc          = pc;
        bus.imm         = imm;
        bus.pred_taken  = pt;
        bus.pred_target = ptgt;
    endtask

    // One request with out_ready high; result checked against hand-computed constants.
    task automatic directed(input string tag, input logic [W-1:0] op1, input logic [W-1:0] op2,
                            input logic [2:0] f3, input logic [W-1:0] pc, input logic [W-1:0] imm,
                            input logic pt, input logic [W-1:0] ptgt, input logic x_taken,
                            input logic [W-1:0] x_npc, input logic x_mis, input logic x_ill);
        bus.out_ready = 1'b1;
        set_req(1'b1, op1, op2, f3, pc, imm, pt, ptgt);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_val({tag, "_valid"}, W'(bus.out_valid), W'(1));
        check_val({tag, "_taken"}, W'(bus.out_taken), W'(x_taken));
        check_val({tag, "_npc"}, bus.out_next_pc, x_npc);
        check_val({tag, "_mis"}, W'(bus.out_mispredict), W'(x_mis));
        check_val({tag, "_ill"}, W'(bus.out_illegal), W'(x_ill));
        step();
    endtask

    initial begin
        logic [W-1:0] hold_npc;
        set_req(1'b0, '0, '0, 3'd0, '0, '0, 1'b0, '0);
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();

        directed("beq_hit", 32'd5, 32'd5, 3'b000, 32'h100, 32'h20, 1'b0, '0,
                 1'b1, 32'h120, 1'b1, 1'b0);
        directed("blt_signed", 32'hFFFF_FFFF, 32'd1, 3'b100, 32'h200, 32'h40, 1'b1, 32'h240,
                 1'b1, 32'h240, 1'b0, 1'b0);
        directed("bltu_unsigned", 32'hFFFF_FFFF, 32'd1, 3'b110, 32'h200, 32'h40, 1'b1, 32'h240,
                 1'b0, 32'h204, 1'b1, 1'b0);
        directed("bge_signed", 32'h8000_0000, 32'd0, 3'b101, 32'h400, 32'h10, 1'b0, '0,
                 1'b0, 32'h404, 1'b0, 1'b0);
        directed("bgeu_unsigned", 32'h8000_0000, 32'd0, 3'b111, 32'h400, 32'h10, 1'b1, 32'h410,
                 1'b1, 32'h410, 1'b0, 1'b0);
        directed("bne_wrap_ok", 32'd1, 32'd2, 3'b001, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10,
                 1'b1, 32'h10, 1'b0, 1'b0);
        directed("bne_wrap_tgt", 32'd1, 32'd2, 3'b001, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h14,
                 1'b1, 32'h10, 1'b1, 1'b0);
        directed("illegal_010", 32'd3, 32'd3, 3'b010, 32'h300, 32'h8, 1'b0, '0,
                 1'b0, 32'h304, 1'b1, 1'b1);
        directed("illegal_011", 32'd3, 32'd4, 3'b011, 32'hFFFF_FFFC, 32'h8, 1'b1, 32'h4,
                 1'b0, 32'h0, 1'b1, 1'b1);

        // Backpressure: second request stalls, then both drain in order.
        bus.out_ready = 1'b0;
        set_req(1'b1, 32'd7, 32'd7, 3'b000, 32'h500, 32'h100, 1'b1, 32'h600);
        step();
        set_req(1'b1, 32'd7, 32'd8, 3'b000, 32'h700, 32'h100, 1'b0, '0);
        @(negedge clk);
        hold_npc = bus.out_next_pc;
        check_val("bp_first_npc", hold_npc, 32'h600);
        step();
        step();
        @(negedge clk);
        check_val("bp_stall_ready", W'(bus.in_ready), '0);
        check_val("bp_hold_npc", bus.out_next_pc, 32'h600);
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_val("bp_second_npc", bus.out_next_pc, 32'h704);
        step();
        @(negedge clk);
        check_val("bp_drained", W'(bus.out_valid), '0);
        step();

        // Flush with a pending stalled result and a same-cycle request.
        bus.out_ready = 1'b0;
        set_req(1'b1, 32'd1, 32'd1, 3'b000, 32'h800, 32'h8, 1'b1, 32'h808);
        step();
        set_req(1'b1, 32'd2, 32'd2, 3'b000, 32'h900, 32'h8, 1'b1, 32'h908);
        flush = 1'b1;
        @(negedge clk);
        check_val("flush_blocks_ready", W'(bus.in_ready), '0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_val("flush_clears_valid", W'(bus.out_valid), '0);
        step();

        // Reset while a result is pending.
        set_req(1'b1, 32'd9, 32'd1, 3'b001, 32'hA00, 32'h20, 1'b1, 32'hA20);
        step();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_valid", W'(bus.out_valid), '0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();

`ifdef BRU_PERF_COUNTERS_EN
        for (int i = 0; i < 20; i++) begin
            set_req(1'b1, 32'(i), 32'(i), 3'b000, 32'h1000, 32'h40, 1'b0, '0);
            step();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_val("sat_branches", W'(cnt_b), W'(15));
        check_val("sat_taken", W'(cnt_t), W'(15));
        check_val("sat_mispred", W'(cnt_m), W'(15));
        step();
        set_req(1'b1, 32'd1, 32'd1, 3'b000, 32'h1000, 32'h40, 1'b0, '0);
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_val("clear_branches", W'(cnt_b), '0);
        check_val("clear_taken", W'(cnt_t), '0);
        check_val("clear_mispred", W'(cnt_m), '0);
        step();
`endif

        // Random traffic: valid, ready, flush and operands all randomized.
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] r_op1, r_pc, r_imm;
            r_op1 = $urandom();
            r_pc  = $urandom();
            r_imm = $urandom();
            set_req(($urandom_range(0, 3) != 0), r_op1,
                    ($urandom_range(0, 3) == 0) ? r_op1 : W'($urandom()),
                    3'($urandom_range(0, 7)), r_pc, r_imm, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? (r_pc + r_imm) : W'($urandom()));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush         = ($urandom_range(0, 15) == 0);
`ifdef BRU_PERF_COUNTERS_EN
            cnt_clear     = ($urandom_range(0, 31) == 0);
`endif
            step();
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        flush         = 1'b0;
`ifdef BRU_PERF_COUNTERS_EN
        cnt_clear     = 1'b0;
`endif
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Registered, handshaked successor to the combinational branch comparator, generalised in width.
- Takes one conditional branch per transfer (operands, funct3, PC, immediate, front-end prediction).
- One cycle later it produces: taken decision, resolved next-PC, mispredict flag and illegal-funct3 flag.
- Sits between execute and fetch-redirect logic; pipeline stalls are handled by valid/ready.

Parameters:
- WIDTH, 32, operand, PC and immediate width in bits (>= 8).
- CNT_WIDTH, 32, width of each performance counter (optional feature only).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline kill
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request this cycle
- op1  input  WIDTH  rs1 value
- op2  input  WIDTH  rs2 value
- funct3  input  3  branch type
- pc  input  WIDTH  branch instruction PC
- imm  input  WIDTH  sign-extended B-immediate
- pred_taken  input  1  front-end predicted direction
- pred_target  input  WIDTH  front-end predicted next-PC
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_taken  output  1  resolved direction
- out_next_pc  output  WIDTH  resolved next-PC
- out_mispredict  output  1  redirect required
- out_illegal  output  1  funct3 not a branch encoding
- cnt_clear  input  1  synchronous counter clear (optional feature only)
- cnt_branches  output  CNT_WIDTH  accepted branches (optional feature only)
- cnt_taken  output  CNT_WIDTH  taken branches (optional feature only)
- cnt_mispred  output  CNT_WIDTH  mispredicts (optional feature only)

Behaviour:
- Reset: one clock, asynchronous active-low rst_n, as already decided. On reset all outputs and internal registers go to 0: out_valid, out_taken, out_next_pc, out_mispredict, out_illegal and all counters.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - Result registers load on accept; out_valid rises the next cycle (latency 1).
  - Output holds stable while out_valid && !out_ready.
  - out_valid falls on out_ready with no new accept.
  - Back-to-back accept every cycle when out_ready is held high: full throughput.
- Decode:
  - 000 BEQ (==), 001 BNE (!=).
  - 100 BLT, 101 BGE: signed compare.
  - 110 BLTU, 111 BGEU: unsigned compare.
  - 010 and 011: out_illegal=1, out_taken=0.
- Target:
  - target = pc + imm, modulo 2^WIDTH (wrap-around, no overflow flag).
  - fallthrough = pc + 4, also modulo 2^WIDTH.
  - out_next_pc = taken ? target : fallthrough.
- Mispredict:
  - out_mispredict = (taken != pred_taken) || (taken && pred_target != target).
  - Forced 1 when illegal, with next_pc = fallthrough.
- flush:
  - Clears out_valid the next edge and blocks any same-cycle accept (in_ready=0 while flush=1).
  - Flush has priority over accept and over out_ready.
- Reset mid-operation: pending result discarded immediately; no partial output.
- Data outputs are don't-care while out_valid=0 but must not be X after reset.

Optional Feature:
- Macro BRU_PERF_COUNTERS_EN.
- Defined:
  - Three CNT_WIDTH counters, incremented on accept (not on output), each saturating at all-ones.
  - cnt_branches +1 per accept; cnt_taken +1 when resolved taken; cnt_mispred +1 when mispredict.
  - Illegal requests count in branches and mispred only.
  - cnt_clear zeroes all three and takes priority over a same-cycle increment.
  - A flushed-cycle request is not accepted, so it is not counted.
- Undefined: cnt_clear and the counter ports do not exist; no counter logic.

Decomposition:
- Shared package (bru_pkg): funct3 localparams (BEQ, BNE, BLT, BGE, BLTU, BGEU) and a branch-result struct typedef {taken, mispredict, illegal, next_pc}.
- One natural sub-module: branch_cond_eval, purely combinational, funct3/op1/op2 -> taken, illegal.
- The registered handshake and counters live in the top module.

Test Plan:
- Reset and BEQ hit: reset, then pc=0x100, imm=0x20, op1=op2=5, funct3=000, pred_taken=0.
  -> one cycle later out_valid=1, out_taken=1, out_next_pc=0x120, out_mispredict=1.
- BLT vs BLTU: op1=0xFFFFFFFF, op2=1.
  -> funct3=100 gives taken=1.
  -> funct3=110 gives taken=0, next_pc=pc+4.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1.
  -> second request stalls (in_ready=0), out_* stable.
  -> on out_ready=1 both results drain in order, one per cycle.
- Wrap and target mispredict: pc=0xFFFFFFF0, imm=0x20, BNE with op1 != op2, pred_taken=1, pred_target=0x10.
  -> next_pc=0x10, mispredict=0.
  -> same request with pred_target=0x14 gives mispredict=1.
- Illegal funct3 and flush:
  -> funct3=010 gives out_illegal=1, taken=0, mispredict=1.
  -> flush asserted while out_valid=1 and out_ready=0 clears out_valid next cycle.
- Counters (BRU_PERF_COUNTERS_EN, CNT_WIDTH=4): 20 taken mispredicted branches.
  -> all counters saturate at 15.
  -> cnt_clear in the same cycle as an accept leaves counters at 0.
